// File: rtl/xor_stream_descrambler.sv
// Serial LFSR descrambler: rebuilds LSB-first bytes from a scrambled bit stream, framed by in_sof.
// Optional macro XOR_DESCR_PARITY_EN adds a ninth odd-parity bit per byte and the par_err output.
module xor_stream_descrambler #(
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int unsigned BYTES_PER_FRAME = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       err_sof
`ifdef XOR_DESCR_PARITY_EN
    ,
    output logic       par_err
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef XOR_DESCR_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif
    localparam logic [7:0] LAST_BYTE = 8'(BYTES_PER_FRAME - 1);

    logic [0:0]  r_state;
    logic [15:0] r_lfsr;
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_bytecnt;
    logic [7:0]  r_shift;
    logic        r_out_valid;
    logic [7:0]  r_out_byte;
    logic        r_out_last;
    logic        r_err_sof;

    logic        w_accept;
    logic        w_decode;
    logic [15:0] w_lfsr_cur;
    logic [15:0] w_lfsr_nxt;
    logic        w_dbit;
    logic [3:0]  w_idx;
    logic [7:0]  w_bytes;
    logic [7:0]  w_byte_new;
    logic        w_byte_done;
    logic        w_frame_done;

    assign in_ready  = !(r_out_valid && !out_ready);
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;
    assign err_sof   = r_err_sof;

    // An in_sof bit is decoded as bit 0 against SEED directly, so restart costs no extra cycle.
    always_comb begin
        w_accept     = in_valid && in_ready;
        w_decode     = w_accept && (in_sof || (r_state == ST_RUN));
        w_lfsr_cur   = in_sof ? SEED : r_lfsr;
        w_lfsr_nxt   = {w_lfsr_cur[14:0],
                        w_lfsr_cur[15] ^ w_lfsr_cur[13] ^ w_lfsr_cur[12] ^ w_lfsr_cur[10]};
        w_dbit       = in_bit ^ w_lfsr_cur[15];
        w_idx        = in_sof ? '0 : r_bitcnt;
        w_bytes      = in_sof ? '0 : r_bytecnt;
        w_byte_new   = in_sof ? '0 : r_shift;
        if (w_idx < 4'd8) begin
            w_byte_new[w_idx[2:0]] = w_dbit;
        end
        w_byte_done  = w_decode && (w_idx == LAST_BIT);
        w_frame_done = w_byte_done && (w_bytes == LAST_BYTE);
    end

`ifdef XOR_DESCR_PARITY_EN
    logic r_par_err;
    logic w_par_err;

    assign par_err   = r_par_err;
    assign w_par_err = ~(^w_byte_new ^ w_dbit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if (w_byte_done) begin
            r_par_err <= w_par_err;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= SEED;
            r_bitcnt    <= '0;
            r_bytecnt   <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_byte  <= '0;
            r_out_last  <= 1'b0;
            r_err_sof   <= 1'b0;
        end else begin
            r_err_sof <= w_accept && in_sof && (r_state == ST_RUN);

            // Loading a new byte takes precedence over the drain, giving back-to-back output.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_byte_done) begin
                r_out_valid <= 1'b1;
                r_out_byte  <= w_byte_new;
                r_out_last  <= w_frame_done;
            end

            if (w_decode) begin
                r_lfsr <= w_lfsr_nxt;
                if (w_frame_done) begin
                    r_state   <= ST_IDLE;
                    r_bitcnt  <= '0;
                    r_bytecnt <= '0;
                    r_shift   <= '0;
                end else if (w_byte_done) begin
                    r_state   <= ST_RUN;
                    r_bitcnt  <= '0;
                    r_bytecnt <= w_bytes + 8'd1;
                    r_shift   <= '0;
                end else begin
                    r_state   <= ST_RUN;
                    r_bitcnt  <= w_idx + 4'd1;
                    r_bytecnt <= w_bytes;
                    r_shift   <= w_byte_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Bench for xor_stream_descrambler: two instances (SEED=0/1 byte, default SEED/4 bytes) against a keystream-table model.
// Honours XOR_DESCR_PARITY_EN to exercise the ninth parity bit and par_err.
module tb_xor_stream_descrambler;

`ifdef XOR_DESCR_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam logic [15:0] SEED0 = 16'h0000;
    localparam logic [15:0] SEED1 = 16'hACE1;
    localparam int          BPF0  = 1;
    localparam int          BPF1  = 4;

    logic clk = 1'b0;
    logic reset, in_valid, in_bit, in_sof, out_ready;
    logic [1:0]       d_ir, d_ov, d_ol, d_err, d_pe;
    logic [1:0][7:0]  d_ob;

    always #5 clk = ~clk;

    xor_stream_descrambler #(.SEED(SEED0), .BYTES_PER_FRAME(BPF0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_ir[0]),
        .in_bit(in_bit), .in_sof(in_sof), .out_valid(d_ov[0]), .out_ready(out_ready),
        .out_byte(d_ob[0]), .out_last(d_ol[0]), .err_sof(d_err[0])
`ifdef XOR_DESCR_PARITY_EN
        , .par_err(d_pe[0])
`endif
    );

    xor_stream_descrambler #(.SEED(SEED1), .BYTES_PER_FRAME(BPF1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_ir[1]),
        .in_bit(in_bit), .in_sof(in_sof), .out_valid(d_ov[1]), .out_ready(out_ready),
        .out_byte(d_ob[1]), .out_last(d_ol[1]), .err_sof(d_err[1])
`ifdef XOR_DESCR_PARITY_EN
        , .par_err(d_pe[1])
`endif
    );

`ifndef XOR_DESCR_PARITY_EN
    assign d_pe = '0;
`endif

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Model: keystream tables per instance, frame bit position, collected byte.
    bit         ks   [2][64];
    int         bpf  [2];
    bit         m_ov [2], m_ol [2], m_err [2], m_pe [2], m_run [2];
    logic [7:0] m_ob [2];
    logic [8:0] m_cur[2];
    int         m_n  [2], m_nb [2];

    initial begin
        logic [15:0] l;
        bpf[0] = BPF0;
        bpf[1] = BPF1;
        for (int k = 0; k < 2; k++) begin
            l = (k == 0) ? SEED0 : SEED1;
            for (int n = 0; n < 64; n++) begin
                ks[k][n] = l[15];
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ov[k] = 0; m_ol[k] = 0; m_err[k] = 0; m_pe[k] = 0; m_run[k] = 0;
                m_ob[k] = '0; m_cur[k] = '0; m_n[k] = 0; m_nb[k] = 0;
            end else begin
                bit acc;
                int p;
                acc = in_valid && !(m_ov[k] && !out_ready);
                m_err[k] = 0;
                if (m_ov[k] && out_ready) m_ov[k] = 0;
                if (acc) begin
                    if (in_sof) begin
                        m_err[k] = m_run[k];
                        m_run[k] = 1; m_n[k] = 0; m_nb[k] = 0; m_cur[k] = '0;
                    end
                    if (m_run[k]) begin
                        p = m_n[k] % NB;
                        m_cur[k][p] = in_bit ^ ks[k][m_n[k]];
                        m_n[k]++;
                        if (p == NB - 1) begin
                            m_ov[k] = 1;
                            m_ob[k] = m_cur[k][7:0];
                            m_pe[k] = ($countones(m_cur[k]) % 2) == 0;
                            m_nb[k]++;
                            m_ol[k] = (m_nb[k] == bpf[k]);
                            if (m_ol[k]) m_run[k] = 0;
                            m_cur[k] = '0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("d%0d.in_ready", k), 9'(d_ir[k]), 9'(!(m_ov[k] && !out_ready)));
                check($sformatf("d%0d.out_valid", k), 9'(d_ov[k]), 9'(m_ov[k]));
                check($sformatf("d%0d.out_byte", k), 9'(d_ob[k]), 9'(m_ob[k]));
                check($sformatf("d%0d.out_last", k), 9'(d_ol[k]), 9'(m_ol[k]));
                check($sformatf("d%0d.err_sof", k), 9'(d_err[k]), 9'(m_err[k]));
`ifdef XOR_DESCR_PARITY_EN
                check($sformatf("d%0d.par_err", k), 9'(d_pe[k]), 9'(m_pe[k]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        in_valid = 1'b1; in_bit = b; in_sof = s;
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ksb0, ksb1, a5;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        tick();
        #1;
        for (int n = 0; n < 8; n++) begin
            ksb0[n] = ks[0][n];
            ksb1[n] = ks[1][n];
        end
        check("model.ks_seed0", 9'(ksb0), 9'h000);
        check("model.ks_ace1", 9'(ksb1), 9'h035);
        tick();
        chk_en = 1'b1;
        check("reset.out_valid", 9'(d_ov), 9'h0);
        check("reset.out_byte", 9'(d_ob[1]), 9'h0);
        reset = 1'b0;

        // Passthrough with SEED=0: A5, one-cycle latency, last on the single byte.
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            send_bit(a5[i], i == 0);
            if (i == 6) check("pass.no_early_valid", 9'(d_ov[0]), 9'h0);
        end
`ifdef XOR_DESCR_PARITY_EN
        send_bit(1'b1, 1'b0);
        check("pass.par_err_ok", 9'(d_pe[0]), 9'h0);
`endif
        check("pass.out_valid", 9'(d_ov[0]), 9'h1);
        check("pass.out_byte", 9'(d_ob[0]), 9'h0A5);
        check("pass.out_last", 9'(d_ol[0]), 9'h1);

        // Default SEED, all-ones input: first byte is the inverted keystream, 8'hCA.
        do_reset();
        for (int i = 0; i < NB; i++) send_bit(1'b1, i == 0);
        check("seed.out_byte", 9'(d_ob[1]), 9'h0CA);
        check("seed.out_last", 9'(d_ol[1]), 9'h0);
        check("seed0.out_byte", 9'(d_ob[0]), 9'h0FF);

        // Backpressure: bytes pending, sink stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_bit = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("stall.in_ready", 9'(d_ir[1]), 9'h0);
        check("stall.out_byte_held", 9'(d_ob[1]), 9'h0CA);
        out_ready = 1'b1;
        #1;
        check("stall.in_ready_release", 9'(d_ir[1]), 9'h1);
        in_valid = 1'b0;
        tick();

        // Abort at bit 5 of the second byte, then decode from SEED again.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        check("abort.err_sof", 9'(d_err[1]), 9'h1);
        check("abort.idle_no_err", 9'(d_err[0]), 9'h0);
        for (int i = 1; i < NB; i++) begin
            send_bit(1'b1, 1'b0);
            if (i == 1) check("abort.err_pulse_end", 9'(d_err[1]), 9'h0);
            if (i == NB - 2) check("abort.no_partial", 9'(d_ov[1]), 9'h0);
        end
        check("abort.out_byte", 9'(d_ob[1]), 9'h0CA);
        check("abort.out_last", 9'(d_ol[1]), 9'h0);

        // IDLE ignores non-sof bits.
        do_reset();
        for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1'b0);
        check("idle.out_valid", 9'(d_ov), 9'h0);
        for (int i = 0; i < NB; i++) send_bit(1'b1, i == 0);
        check("idle.then_frame", 9'(d_ob[1]), 9'h0CA);

`ifdef XOR_DESCR_PARITY_EN
        do_reset();
        for (int i = 0; i < 8; i++) send_bit(a5[i], i == 0);
        send_bit(1'b0, 1'b0);
        check("parity.par_err_bad", 9'(d_pe[0]), 9'h1);
`endif

        // Randomized traffic with occasional aborts, stalls and resets.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_bit    = 1'($urandom);
            in_sof    = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xor_stream_descrambler.md
XOR_STREAM_DESCRAMBLER -- requirements
Module: xor_stream_descrambler

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1: LFSR load value at every start of frame.
REQ-002 SHALL have parameter BYTES_PER_FRAME, default 4: decoded bytes per frame, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_bit/in_sof valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts the input bit this cycle.
REQ-007 SHALL have port in_bit, input, 1: scrambled serial bit.
REQ-008 SHALL have port in_sof, input, 1: this bit is bit 0 of a new frame.
REQ-009 SHALL have port out_valid, output, 1: out_byte holds a decoded byte.
REQ-010 SHALL have port out_ready, input, 1: sink accepts out_byte.
REQ-011 SHALL have port out_byte, output, 8: decoded byte.
REQ-012 SHALL have port out_last, output, 1: out_byte is the final byte of its frame.
REQ-013 SHALL have port err_sof, output, 1: one-cycle pulse when a frame is aborted by in_sof.

Function
REQ-014 SHALL accept a bit only on a cycle with in_valid && in_ready.
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-016 SHALL implement states IDLE and RUN; reset enters IDLE.
REQ-017 In IDLE, SHALL discard accepted bits with in_sof=0, with no other effect.
REQ-018 An accepted bit with in_sof=1 SHALL load the LFSR with SEED, clear the bit and byte counters, decode the bit as bit 0, and enter RUN.
REQ-019 SHALL use a 16-bit Fibonacci LFSR: keystream bit = lfsr[15]; per accepted bit, shift left with new lfsr[0] = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
REQ-020 SHALL compute decoded bit = in_bit ^ keystream bit; bits are assembled LSB-first.
REQ-021 On the 8th decoded bit, SHALL register the byte to out_byte with out_valid=1 on the next cycle (latency 1 clock from the 8th accepted bit).
REQ-022 SHALL set out_last=1 with the BYTES_PER_FRAME-th byte and return to IDLE on that same accept.
REQ-023 SHALL hold out_valid, out_byte and out_last stable until out_valid && out_ready.
REQ-024 Simultaneous sink accept and completion of a new byte SHALL load the new byte with no bubble.
REQ-025 In RUN, an accepted in_sof=1 SHALL discard the partial byte, pulse err_sof for 1 cycle, and restart per REQ-018; an already-registered output byte is unaffected.
REQ-026 SEED=0 SHALL give an all-zero keystream, i.e. bit passthrough (required test mode).

Reset
REQ-027 With reset high at posedge: state=IDLE, out_valid=0, out_byte=8'h00, out_last=0, err_sof=0, counters=0, lfsr=SEED.
REQ-028 Reset SHALL override all other inputs in the same cycle; a frame interrupted by reset is dropped entirely.

Configuration
REQ-029 With macro XOR_DESCR_PARITY_EN defined, each byte SHALL carry a 9th accepted bit (descrambled, odd parity over the 8 data bits); port par_err (output, 1) SHALL be valid with out_valid and set when parity mismatches.
REQ-030 Without XOR_DESCR_PARITY_EN, bytes SHALL be 8 bits, the par_err port SHALL be absent, and no parity logic SHALL exist.

Verification
REQ-031 SEED=0, BYTES_PER_FRAME=1, bits 1,0,1,0,0,1,0,1 with in_sof on the first -> out_byte=8'hA5, out_last=1, out_valid one cycle after the 8th bit.
REQ-032 Default SEED, frame bit 0 in_bit=1 -> decoded bit0=0 (lfsr[15]=1); a reference-model comparison over 4 bytes matches exactly, out_last only on byte 4.
REQ-033 out_ready=0 while a byte is pending -> in_ready=0 and out_byte held; out_ready=1 -> in_ready rises in the same cycle.
REQ-034 in_sof at bit 5 of byte 2 -> err_sof single pulse, next 8 bits decode as byte 0 using SEED, no partial byte emitted.
REQ-035 Bits without in_sof in IDLE (e.g. 20 bits) -> no out_valid, lfsr unchanged.
REQ-036 PARITY_EN, SEED=0, data 8'hA5 with parity bit 1 -> par_err=0; with parity bit 0 -> par_err=1.
